// File: rtl/rom_loader_pkg.sv
// Shared types and sizes for the ROM loader and the instruction ROM it feeds.
// Stream layout: 4-byte little-endian word count, then that many little-endian words.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int ROM_DEPTH  = 1024;

endpackage

// File: rtl/byte_packer.sv
// Packs little-endian bytes into a 32-bit word; reused for the length header and data words.
// word_o/word_done_o are combinational so the consumer can register the word on the accepting edge.
module byte_packer
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (push_i) begin
            // byte k of the word lands in bits [8k+7:8k]
            word_d[{cnt_q, 3'b000} +: 8] = byte_i;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_d;
    assign word_done_o = push_i && !clr_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/rom_loader.sv
// Receives a length-prefixed byte stream and writes it into the instruction ROM, holding the core meanwhile.
// Write issues one cycle after a word's last byte; byte_ready_o depends only on state, so one byte per cycle is sustained.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int DEPTH   = ROM_DEPTH,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        rom_we_o,
    output logic [31:0] rom_waddr_o,
    output logic [31:0] rom_wdata_o,
    output logic        hold_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      n_q, n_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             tmo_expire;
    logic             pk_clr;
    logic [31:0]      pk_word;
    logic             pk_done;

    assign byte_ready_o = (state_q == ST_LEN) || (state_q == ST_DATA);
    // a start in the same cycle as a byte wins: the byte is not consumed
    assign xfer         = byte_valid_i && byte_ready_o && !load_start_i;
    assign tmo_expire   = byte_ready_o && !xfer && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign pk_clr       = load_start_i || tmo_expire;

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (pk_clr),
        .push_i      (xfer),
        .byte_i      (byte_data_i),
        .word_o      (pk_word),
        .word_done_o (pk_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        tmo_d   = tmo_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        if (load_start_i) begin
            state_d = ST_LEN;
            idx_d   = '0;
            n_d     = '0;
            tmo_d   = '0;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (byte_ready_o) begin
            tmo_d = xfer ? '0 : tmo_q + 1'b1;
            if (tmo_expire) begin
                state_d = ST_ERR;
                err_d   = 1'b1;
                hold_d  = 1'b0;
            end else if (pk_done) begin
                if (state_q == ST_LEN) begin
                    n_d = pk_word;
                    if (pk_word == 32'd0 || pk_word > 32'(DEPTH)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    we_d    = 1'b1;
                    waddr_d = {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
                    wdata_d = pk_word;
                    idx_d   = idx_q + 1'b1;
                    if (32'(idx_q) == n_q - 32'd1) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rom_we_o    = we_q;
    assign rom_waddr_o = waddr_q;
    assign rom_wdata_o = wdata_q;
    assign hold_o      = hold_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: randomized loads, expected ROM writes queued by the driver and popped by a write monitor.
module tb_rom_loader;

    localparam int DEPTH   = 1024;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o;
    logic        rom_we_o;
    logic [31:0] rom_waddr_o;
    logic [31:0] rom_wdata_o;
    logic        hold_o;
    logic        done_o;
    logic        err_o;

    rom_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .rom_we_o     (rom_we_o),
        .rom_waddr_o  (rom_waddr_o),
        .rom_wdata_o  (rom_wdata_o),
        .hold_o       (hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] rom_model [DEPTH];
    logic [31:0] ref_words [DEPTH];
    logic [31:0] last_addr = '0;
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          ready_drops = 0;
    bit          watch_ready = 1'b0;

    // Write monitor: behaves as the ROM and checks every strobe against the queue.
    always @(negedge clk) begin
        wr_t e;
        if (watch_ready && !byte_ready_o) ready_drops++;
        if (rst_n && rom_we_o) begin
            wr_count++;
            last_addr = rom_waddr_o;
            rom_model[rom_waddr_o[11:2]] = rom_wdata_o;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", rom_waddr_o, rom_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (rom_waddr_o !== e.addr || rom_wdata_o !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             rom_waddr_o, rom_wdata_o, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (byte_ready_o) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL byte_ready_wait: got no ready in 64 cycles, expected ready");
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_wr, input logic [31:0] addr, input bit gaps);
        int n;
        if (expect_wr) exp_q.push_back('{addr, w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gaps) begin
                n = $urandom_range(0, 4);
                if (n > 0) begin
                    byte_valid_i = 1'b0;
                    repeat (n) tick();
                end
            end
        end
    endtask

    // Full load of n words (n assumed legal), words drawn at random into ref_words.
    task automatic do_load(input int n, input bit gaps);
        start();
        send_word(32'(n), 1'b0, 32'h0, gaps);
        for (int i = 0; i < n; i++) begin
            ref_words[i] = $urandom;
            send_word(ref_words[i], 1'b1, 32'(4 * i), gaps);
        end
        byte_valid_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic exp_err);
        @(negedge clk);
        chk({tag, "_done"}, done_o, exp_done);
        chk({tag, "_err"}, err_o, exp_err);
        chk({tag, "_hold"}, hold_o, 1'b0);
        chk({tag, "_pending"}, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int wc0;
        logic [31:0] w0;

        // reset values
        @(negedge clk);
        chk("rst_ready", byte_ready_o, 1'b0);
        chk("rst_we", rom_we_o, 1'b0);
        chk("rst_waddr", rom_waddr_o, 32'h0);
        chk("rst_wdata", rom_wdata_o, 32'h0);
        chk("rst_hold", hold_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic load with the reference byte stream
        start();
        @(negedge clk);
        chk("basic_hold_after_start", hold_o, 1'b1);
        chk("basic_ready_after_start", byte_ready_o, 1'b1);
        tick();
        wc0 = wr_count;
        send_word(32'h2, 1'b0, 32'h0, 1'b0);
        send_word(32'h00000013, 1'b1, 32'h0, 1'b0);
        send_word(32'h00100093, 1'b1, 32'h4, 1'b0);
        byte_valid_i = 1'b0;
        tick();
        check_end("basic", 1'b1, 1'b0);
        chk("basic_writes", wr_count - wc0, 2);

        // randomized loads with random inter-byte gaps
        for (int r = 0; r < 4; r++) begin
            wc0 = wr_count;
            do_load($urandom_range(1, 9), 1'b1);
            check_end("rand", 1'b1, 1'b0);
        end

        // full-depth load at one byte per cycle
        start();
        watch_ready = 1'b1;
        wc0 = wr_count;
        send_word(32'(DEPTH), 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            ref_words[i] = $urandom;
            send_word(ref_words[i], 1'b1, 32'(4 * i), 1'b0);
        end
        watch_ready = 1'b0;
        byte_valid_i = 1'b0;
        tick();
        tick();
        chk("thru_ready_drops", ready_drops, 0);
        chk("thru_writes", wr_count - wc0, DEPTH);
        chk("thru_last_addr", last_addr, 32'hFFC);
        check_end("thru", 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) chk("thru_readback", rom_model[i], ref_words[i]);

        // illegal lengths
        for (int r = 0; r < 2; r++) begin
            start();
            wc0 = wr_count;
            send_word((r == 0) ? 32'd0 : 32'(DEPTH + 1), 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            chk("badlen_err", err_o, 1'b1);
            chk("badlen_hold", hold_o, 1'b0);
            chk("badlen_done", done_o, 1'b0);
            byte_valid_i = 1'b0;
            repeat (4) tick();
            chk("badlen_writes", wr_count - wc0, 0);
            chk("badlen_ready", byte_ready_o, 1'b0);
        end

        // idle timeout after one full word and a partial one
        start();
        wc0 = wr_count;
        send_word(32'd2, 1'b0, 32'h0, 1'b0);
        w0 = $urandom;
        send_word(w0, 1'b1, 32'h0, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        byte_valid_i = 1'b0;
        repeat (15) tick();
        @(negedge clk);
        chk("tmo_err_at_15", err_o, 1'b0);
        chk("tmo_hold_at_15", hold_o, 1'b1);
        tick();
        @(negedge clk);
        chk("tmo_err_at_16", err_o, 1'b1);
        chk("tmo_hold_at_16", hold_o, 1'b0);
        chk("tmo_writes", wr_count - wc0, 1);
        tick();

        // restart clears err, drops a concurrent byte and restarts at address 0
        start();
        @(negedge clk);
        chk("restart_err_cleared", err_o, 1'b0);
        chk("restart_hold", hold_o, 1'b1);
        tick();
        send_word(32'd3, 1'b0, 32'h0, 1'b0);
        w0 = $urandom;
        send_word(w0, 1'b1, 32'h0, 1'b0);
        send_byte(8'h5A);
        send_byte(8'hA5);
        load_start_i = 1'b1;
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hAB;
        tick();
        load_start_i = 1'b0;
        wc0 = wr_count;
        send_word(32'd2, 1'b0, 32'h0, 1'b0);
        ref_words[0] = $urandom;
        ref_words[1] = $urandom;
        send_word(ref_words[0], 1'b1, 32'h0, 1'b0);
        send_word(ref_words[1], 1'b1, 32'h4, 1'b0);
        byte_valid_i = 1'b0;
        tick();
        check_end("restart", 1'b1, 1'b0);
        chk("restart_writes", wr_count - wc0, 2);
        start();
        @(negedge clk);
        chk("restart_done_cleared", done_o, 1'b0);
        tick();

        // asynchronous reset between bytes 2 and 3 of a word
        send_word(32'd2, 1'b0, 32'h0, 1'b0);
        w0 = $urandom;
        send_word(w0, 1'b1, 32'h0, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        byte_valid_i = 1'b0;
        tick();
        wc0 = wr_count;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", byte_ready_o, 1'b0);
        chk("arst_we", rom_we_o, 1'b0);
        chk("arst_waddr", rom_waddr_o, 32'h0);
        chk("arst_wdata", rom_wdata_o, 32'h0);
        chk("arst_hold", hold_o, 1'b0);
        chk("arst_done", done_o, 1'b0);
        chk("arst_err", err_o, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'(i + 3);
            tick();
        end
        byte_valid_i = 1'b0;
        tick();
        @(negedge clk);
        chk("arst_no_write", wr_count - wc0, 0);
        chk("arst_idle_ready", byte_ready_o, 1'b0);
        chk("arst_idle_hold", hold_o, 1'b0);
        tick();
        do_load(3, 1'b1);
        check_end("after_arst", 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
